axi_wr_arb: RTL and testbench
=============================

# axi_wr_arb

Two-requester write arbiter in front of the LSU-side port of the AXI write interface. Grants the single downstream write path to one requester per transaction: command, then all data beats, then the write response. Returns the response only to the owning requester. Round-robin fairness; the downstream interface accepts one transaction at a time (its command ready stays low while any ID is outstanding), so the arbiter holds the grant end to end.

## Interface
- NREQ, 2, number of requesters (fixed; not re-parameterisable)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqN_awvld / reqN_awrdy  in/out  1  per-requester command handshake (N = 0, 1)
- reqN_awaddr  in  10  write address
- reqN_awlen  in  8  beats − 1
- reqN_awsize / reqN_awburst / reqN_awstr  in  3/2/3  AXI size, burst, stride code
- reqN_oram_addr  in  12  output-RAM tag for the transaction
- reqN_wvld / reqN_wrdy  in/out  1  per-requester data handshake
- reqN_wdata / reqN_wstrb / reqN_wlast  in  64/8/1  write beat
- reqN_bvld / reqN_brdy  out/in  1  response handshake
- reqN_bresp  out  2  write response code
- reqN_resp_oram_addr  out  12  tag echoed with the response
- m_aw* (vld, addr, len, size, burst, str, oram_addr)  out  —  command to the write interface; m_awrdy  in  1
- m_wvld, m_wdata, m_wstrb, m_wlast  out; m_wrdy  in  —  beat to the write interface
- m_bvld, m_bresp, m_resp_oram_addr  in; m_brdy  out  —  response from the write interface
- err_beat  out  1  sticky beat-count mismatch flag

## Operation
- FSM states: IDLE, CMD, DATA, RESP.
- IDLE: if any reqN_awvld, grant the requester preferred by rr_ptr; otherwise grant the only requester asking. Latch that requester's command fields and oram_addr into the command registers. Pulse reqN_awrdy for the grant cycle. Set owner. Go to CMD.
- CMD: m_awvld = 1 from a register. On m_awvld & m_awrdy, clear beat_cnt to 0 and go to DATA.
- DATA:
  - m_w* = owner's w* fields.
  - m_wvld = owner_wvld.
  - owner_wrdy = m_wrdy.
  - Non-owner wrdy = 0.
  - On each accepted beat, beat_cnt += 1 (8-bit).
  - The accepted beat with beat_cnt == latched awlen moves the FSM to RESP.
- RESP:
  - owner_bvld = m_bvld.
  - bresp and resp_oram_addr are passed through combinationally.
  - m_brdy = owner_brdy.
  - On handshake: rr_ptr = ~owner, go to IDLE.
- Non-owner bvld, awrdy and wrdy are 0 in every state except that requester's grant cycle.
- rr_ptr changes only on response completion. If both requesters hold awvld, service alternates 0,1,0,1.
- A requester's awvld asserted during another requester's transaction waits in IDLE; no queueing.
- awlen = 255: the 256-beat burst completes; beat_cnt wraps to 0 only after the transition to RESP.

## Timing
- Reset values: all *vld, *rdy, m_wlast and err_beat = 0; m_aw* data fields = 0; FSM = IDLE; rr_ptr = 0; beat_cnt = 0.
- Request to m_awvld: 1 cycle (awvld at cycle t, awrdy pulse at t, m_awvld high at t+1).
- Data and response paths add zero latency; they are combinational passthrough gated by state.
- m_awvld holds high with stable fields until m_awrdy.
- Earliest return to IDLE is the cycle after the response handshake. A new grant is possible in that IDLE cycle, so a 1-beat transaction takes at least 4 cycles.
- Reset asserted mid-transaction: immediate return to reset values. Partial bursts are not resumed; the downstream block is reset by the same rst_n.

## Configuration
- WR_ARB_BEAT_CHK_EN defined:
  - m_wlast is generated internally as (beat_cnt == awlen) in DATA; the requester's wlast is ignored for signalling.
  - If an accepted beat has reqN_wlast different from the generated value, err_beat sets.
  - err_beat clears only on reset.
- WR_ARB_BEAT_CHK_EN undefined: m_wlast = owner_wlast; err_beat is tied 0. The FSM still ends DATA on the beat count.

## Test plan
- req0 only, awlen=3, awaddr=0x040, oram_addr=0x123, m_awrdy=1, m_wrdy=1 → 4 beats forwarded in order, m_wlast on beat 4, then req0_bvld with resp_oram_addr=0x123 and bresp=0; req1 sees no vld or rdy throughout.
- req0 and req1 both holding awvld, each with awlen=0 → grants go 0,1,0,1; each grant follows the previous response handshake, with the command on the following cycle.
- m_awrdy held low 5 cycles → m_awvld stays high with stable fields; no wrdy to any requester until the command handshake.
- awlen=255 with m_wrdy toggling every cycle → exactly 256 beats accepted, then RESP; beat_cnt==0 after.
- With WR_ARB_BEAT_CHK_EN: awlen=1, requester asserts wlast on beat 1 → err_beat=1 sticky; m_wlast still asserted only on beat 2.
- rst_n low during DATA beat 2 of 4 → all outputs return to reset values asynchronously; after release, req1 request granted normally.

Source files
------------

// File: rtl/axi_wr_arb_if.sv
// axi_wr_arb_if: one AXI-style write port (command, data beat, response) carrying the
// extra stride code and output-RAM tag used by the LSU write path.
//
// Modports:
//   master - issues commands and beats, receives responses (drives *vld, brdy)
//   slave  - accepts commands and beats, returns responses (drives awrdy, wrdy, b*)
//
// Signals:
//   awvld/awrdy, awaddr[9:0], awlen[7:0] (beats-1), awsize[2:0], awburst[1:0],
//   awstr[2:0], oram_addr[11:0]                         command channel
//   wvld/wrdy, wdata[63:0], wstrb[7:0], wlast           data channel
//   bvld/brdy, bresp[1:0], resp_oram_addr[11:0]         response channel
interface axi_wr_arb_if;
    logic        awvld;
    logic        awrdy;
    logic [9:0]  awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [2:0]  awstr;
    logic [11:0] oram_addr;

    logic        wvld;
    logic        wrdy;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    logic        bvld;
    logic        brdy;
    logic [1:0]  bresp;
    logic [11:0] resp_oram_addr;

    modport master (
        output awvld, awaddr, awlen, awsize, awburst, awstr, oram_addr,
        input  awrdy,
        output wvld, wdata, wstrb, wlast,
        input  wrdy,
        input  bvld, bresp, resp_oram_addr,
        output brdy
    );

    modport slave (
        input  awvld, awaddr, awlen, awsize, awburst, awstr, oram_addr,
        output awrdy,
        input  wvld, wdata, wstrb, wlast,
        output wrdy,
        output bvld, bresp, resp_oram_addr,
        input  brdy
    );
endinterface

// File: rtl/axi_wr_arb.sv
// axi_wr_arb: two-requester round-robin arbiter in front of a single write interface.
// One requester owns the downstream path for a whole transaction (command, every data
// beat, response); the response is routed back only to the owner.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   req0, req1  requester ports (slave side of axi_wr_arb_if)
//   m           downstream write interface (master side of axi_wr_arb_if)
//   err_beat    sticky flag: a requester's wlast disagreed with the beat count
//
// Optional feature: define WR_ARB_BEAT_CHK_EN to generate m.wlast from the latched
// awlen and to flag wlast mismatches on err_beat. Undefined, m.wlast follows the
// owner's wlast and err_beat is tied low. DATA always ends on the beat count.
module axi_wr_arb (
    input  logic         clk,
    input  logic         rst_n,
    axi_wr_arb_if.slave  req0,
    axi_wr_arb_if.slave  req1,
    axi_wr_arb_if.master m,
    output logic         err_beat
);
    typedef enum logic [1:0] {StIdle, StCmd, StData, StResp} state_e;

    state_e     state_q;
    logic       owner_q;
    logic       rr_ptr_q;
    logic [7:0] beat_cnt_q;

    logic in_idle, in_data, in_resp;
    assign in_idle = (state_q == StIdle);
    assign in_data = (state_q == StData);
    assign in_resp = (state_q == StResp);

    // rr_ptr only breaks ties; a lone requester always wins.
    logic gnt0, gnt1;
    assign gnt0 = in_idle & req0.awvld & (~rr_ptr_q | ~req1.awvld);
    assign gnt1 = in_idle & req1.awvld & ( rr_ptr_q | ~req0.awvld);
    assign req0.awrdy = gnt0;
    assign req1.awrdy = gnt1;

    // Owner-selected requester signals
    logic        own_wvld, own_wlast, own_brdy;
    logic [63:0] own_wdata;
    logic [7:0]  own_wstrb;
    assign own_wvld  = owner_q ? req1.wvld  : req0.wvld;
    assign own_wlast = owner_q ? req1.wlast : req0.wlast;
    assign own_wdata = owner_q ? req1.wdata : req0.wdata;
    assign own_wstrb = owner_q ? req1.wstrb : req0.wstrb;
    assign own_brdy  = owner_q ? req1.brdy  : req0.brdy;

    logic beat_acc, last_beat, resp_done;
    assign beat_acc  = in_data & own_wvld & m.wrdy;
    assign last_beat = (beat_cnt_q == m.awlen);
    assign resp_done = in_resp & m.bvld & own_brdy;

    // Data path: zero-latency passthrough, gated to the owner while in DATA
    assign m.wvld    = in_data & own_wvld;
    assign m.wdata   = in_data ? own_wdata : '0;
    assign m.wstrb   = in_data ? own_wstrb : '0;
`ifdef WR_ARB_BEAT_CHK_EN
    assign m.wlast   = in_data & last_beat;
`else
    assign m.wlast   = in_data & own_wlast;
`endif
    assign req0.wrdy = in_data & ~owner_q & m.wrdy;
    assign req1.wrdy = in_data &  owner_q & m.wrdy;

    // Response path: zero-latency passthrough, gated to the owner while in RESP
    assign m.brdy               = in_resp & own_brdy;
    assign req0.bvld            = in_resp & ~owner_q & m.bvld;
    assign req1.bvld            = in_resp &  owner_q & m.bvld;
    assign req0.bresp           = (in_resp & ~owner_q) ? m.bresp : '0;
    assign req1.bresp           = (in_resp &  owner_q) ? m.bresp : '0;
    assign req0.resp_oram_addr  = (in_resp & ~owner_q) ? m.resp_oram_addr : '0;
    assign req1.resp_oram_addr  = (in_resp &  owner_q) ? m.resp_oram_addr : '0;

    // m.aw* are the latched command registers; m.awlen doubles as the beat-count target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            beat_cnt_q  <= '0;
            m.awvld     <= 1'b0;
            m.awaddr    <= '0;
            m.awlen     <= '0;
            m.awsize    <= '0;
            m.awburst   <= '0;
            m.awstr     <= '0;
            m.oram_addr <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt0 | gnt1) begin
                        owner_q     <= gnt1;
                        m.awvld     <= 1'b1;
                        m.awaddr    <= gnt1 ? req1.awaddr    : req0.awaddr;
                        m.awlen     <= gnt1 ? req1.awlen     : req0.awlen;
                        m.awsize    <= gnt1 ? req1.awsize    : req0.awsize;
                        m.awburst   <= gnt1 ? req1.awburst   : req0.awburst;
                        m.awstr     <= gnt1 ? req1.awstr     : req0.awstr;
                        m.oram_addr <= gnt1 ? req1.oram_addr : req0.oram_addr;
                        state_q     <= StCmd;
                    end
                end
                StCmd: begin
                    if (m.awrdy) begin
                        m.awvld    <= 1'b0;
                        beat_cnt_q <= '0;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (beat_acc) begin
                        // Wraps to 0 on the final beat of a 256-beat burst, same edge as RESP.
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (last_beat) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (resp_done) begin
                        rr_ptr_q <= ~owner_q;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WR_ARB_BEAT_CHK_EN
    logic err_beat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_beat_q <= 1'b0;
        end else if (beat_acc && (own_wlast != last_beat)) begin
            err_beat_q <= 1'b1;
        end
    end
    assign err_beat = err_beat_q;
`else
    assign err_beat = 1'b0;
`endif
endmodule

// File: tb/tb_axi_wr_arb.sv
// tb_axi_wr_arb: randomized self-checking bench for axi_wr_arb. Requesters and the
// downstream write interface are modelled at transaction level; expectations come from
// the arbitration rules (ownership, round-robin tie-break, beat counts, routing).
module tb_axi_wr_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic err_beat;
    always #5 clk = ~clk;

    axi_wr_arb_if req0_if ();
    axi_wr_arb_if req1_if ();
    axi_wr_arb_if m_if ();

    axi_wr_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0_if),
        .req1     (req1_if),
        .m        (m_if),
        .err_beat (err_beat)
    );

    typedef struct {
        logic        req;
        logic [9:0]  addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  str;
        logic [11:0] oram;
        logic [1:0]  bresp;
        logic [31:0] tag;
        logic        bad;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side model
    txn_t r_cur[2];
    int   r_phase[2];  // 0 requesting, 1 sending beats, 2 awaiting response
    int   r_beat[2];
    int   r_left[2];
    logic r_awvld[2], r_wvld[2], r_brdy[2];
    // Downstream-side model
    txn_t gq[$];       // granted, command not yet accepted downstream
    txn_t ds_cur;
    int   ds_phase, ds_beat, ds_bdelay, aw_wait;
    logic m_awrdy_d, m_wrdy_d, m_bvld_d, tog;
    bit   rr_m, err_m;
    // Knobs
    int   p_req, p_wvld, p_brdy, p_awrdy, p_wrdy, len_max, fixed_len, aw_delay;
    bit   wrdy_toggle, bad_next;

    logic o_awrdy[2], o_wrdy[2], o_bvld[2];
    logic [1:0]  o_bresp[2];
    logic [11:0] o_roram[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pct(int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic txn_t new_txn(int r);
        txn_t t;
        t.req   = 1'(r);
        t.addr  = 10'($urandom);
        t.len   = (fixed_len >= 0) ? 8'(fixed_len) : 8'($urandom_range(len_max));
        t.size  = 3'($urandom);
        t.burst = 2'($urandom);
        t.str   = 3'($urandom);
        t.oram  = 12'($urandom);
        t.bresp = 2'($urandom);
        t.tag   = $urandom;
        t.bad   = bad_next && (t.len != 0);
        return t;
    endfunction

    function automatic logic [63:0] beat_data(txn_t t, int b);
        return {t.tag, t.oram, 12'(b), 8'(b * 7)};
    endfunction

    function automatic logic [7:0] beat_strb(txn_t t, int b);
        return t.tag[7:0] ^ 8'(b);
    endfunction

    function automatic logic req_wlast(int r);
        return (r_beat[r] == int'(r_cur[r].len)) ^ (r_cur[r].bad && r_beat[r] == 0);
    endfunction

    function automatic logic [37:0] cmd_bits(txn_t t);
        return {t.addr, t.len, t.size, t.burst, t.str, t.oram};
    endfunction

    function automatic logic [37:0] m_cmd_bits();
        return {m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awstr, m_if.oram_addr};
    endfunction

    task automatic apply();
        req0_if.awvld     = r_awvld[0];
        req0_if.awaddr    = r_cur[0].addr;
        req0_if.awlen     = r_cur[0].len;
        req0_if.awsize    = r_cur[0].size;
        req0_if.awburst   = r_cur[0].burst;
        req0_if.awstr     = r_cur[0].str;
        req0_if.oram_addr = r_cur[0].oram;
        req0_if.wvld      = r_wvld[0];
        req0_if.wdata     = beat_data(r_cur[0], r_beat[0]);
        req0_if.wstrb     = beat_strb(r_cur[0], r_beat[0]);
        req0_if.wlast     = r_wvld[0] & req_wlast(0);
        req0_if.brdy      = r_brdy[0];
        req1_if.awvld     = r_awvld[1];
        req1_if.awaddr    = r_cur[1].addr;
        req1_if.awlen     = r_cur[1].len;
        req1_if.awsize    = r_cur[1].size;
        req1_if.awburst   = r_cur[1].burst;
        req1_if.awstr     = r_cur[1].str;
        req1_if.oram_addr = r_cur[1].oram;
        req1_if.wvld      = r_wvld[1];
        req1_if.wdata     = beat_data(r_cur[1], r_beat[1]);
        req1_if.wstrb     = beat_strb(r_cur[1], r_beat[1]);
        req1_if.wlast     = r_wvld[1] & req_wlast(1);
        req1_if.brdy      = r_brdy[1];
        m_if.awrdy          = m_awrdy_d;
        m_if.wrdy           = m_wrdy_d;
        m_if.bvld           = m_bvld_d;
        m_if.bresp          = ds_cur.bresp;
        m_if.resp_oram_addr = ds_cur.oram;
    endtask

    task automatic reset_model();
        for (int r = 0; r < 2; r++) begin
            r_cur[r]   = '{default: '0};
            r_phase[r] = 0;
            r_beat[r]  = 0;
            r_left[r]  = 0;
            r_awvld[r] = 1'b0;
            r_wvld[r]  = 1'b0;
            r_brdy[r]  = 1'b0;
        end
        gq.delete();
        ds_cur    = '{default: '0};
        ds_phase  = 0;
        ds_beat   = 0;
        ds_bdelay = 0;
        aw_wait   = 0;
        m_awrdy_d = 1'b0;
        m_wrdy_d  = 1'b0;
        m_bvld_d  = 1'b0;
        tog       = 1'b0;
        rr_m      = 1'b0;
        err_m     = 1'b0;
        apply();
    endtask

    task automatic load(input int n0, input int n1);
        r_left[0] = n0;
        r_left[1] = n1;
        for (int r = 0; r < 2; r++) begin
            if (r_left[r] > 0) r_cur[r] = new_txn(r);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            r_awvld[r] = (r_phase[r] == 0 && r_left[r] > 0) && (r_awvld[r] || pct(p_req));
            r_wvld[r]  = (r_phase[r] == 1) && (r_wvld[r] || pct(p_wvld));
            r_brdy[r]  = pct(p_brdy);
        end
        m_awrdy_d = (gq.size() > 0 && aw_wait < aw_delay) ? 1'b0 : pct(p_awrdy);
        m_wrdy_d  = wrdy_toggle ? tog : pct(p_wrdy);
        m_bvld_d  = (ds_phase == 2 && ds_bdelay == 0);
        apply();
    endtask

    task automatic sample();
        logic idle, exp_wv, exp_bv, exp_last;
        logic exp_aw[2];
        int   own;
        o_awrdy[0] = req0_if.awrdy;  o_awrdy[1] = req1_if.awrdy;
        o_wrdy[0]  = req0_if.wrdy;   o_wrdy[1]  = req1_if.wrdy;
        o_bvld[0]  = req0_if.bvld;   o_bvld[1]  = req1_if.bvld;
        o_bresp[0] = req0_if.bresp;  o_bresp[1] = req1_if.bresp;
        o_roram[0] = req0_if.resp_oram_addr;
        o_roram[1] = req1_if.resp_oram_addr;

        check_eq("err_beat", err_beat, err_m);
        idle = (ds_phase == 0 && gq.size() == 0);
        for (int r = 0; r < 2; r++) begin
            exp_aw[r] = idle && r_awvld[r] && (!r_awvld[1 - r] || int'(rr_m) == r);
            check_eq($sformatf("awrdy%0d", r), o_awrdy[r], exp_aw[r]);
        end
        check_eq("m_awvld", m_if.awvld, gq.size() > 0);
        if (gq.size() > 0) check_eq("m_aw_fields", m_cmd_bits(), cmd_bits(gq[0]));

        own = int'(ds_cur.req);
        for (int r = 0; r < 2; r++) begin
            check_eq($sformatf("wrdy%0d", r), o_wrdy[r], ds_phase == 1 && own == r && m_wrdy_d);
        end
        exp_wv = (ds_phase == 1) && r_wvld[own];
        check_eq("m_wvld", m_if.wvld, exp_wv);
        check_eq("m_brdy", m_if.brdy, ds_phase == 2 && r_brdy[own]);
        for (int r = 0; r < 2; r++) begin
            exp_bv = (ds_phase == 2) && own == r && m_bvld_d;
            check_eq($sformatf("bvld%0d", r), o_bvld[r], exp_bv);
            if (exp_bv) begin
                check_eq($sformatf("bresp%0d", r), o_bresp[r], ds_cur.bresp);
                check_eq($sformatf("resp_oram%0d", r), o_roram[r], ds_cur.oram);
            end
        end

        // Handshakes taking place at the coming rising edge
        if (gq.size() > 0) begin
            if (m_awrdy_d) begin
                ds_cur   = gq.pop_front();
                ds_phase = 1;
                ds_beat  = 0;
                aw_wait  = 0;
            end else begin
                aw_wait++;
            end
        end else if (exp_wv && m_wrdy_d) begin
            check_eq("m_wdata", m_if.wdata, beat_data(ds_cur, ds_beat));
            check_eq("m_wstrb", m_if.wstrb, beat_strb(ds_cur, ds_beat));
`ifdef WR_ARB_BEAT_CHK_EN
            exp_last = (ds_beat == int'(ds_cur.len));
            if (req_wlast(own) != exp_last) err_m = 1'b1;
`else
            exp_last = req_wlast(own);
`endif
            check_eq("m_wlast", m_if.wlast, exp_last);
            r_wvld[own] = 1'b0;
            if (ds_beat == int'(ds_cur.len)) begin
                ds_phase     = 2;
                ds_bdelay    = int'($urandom_range(3));
                r_phase[own] = 2;
            end
            ds_beat++;
            r_beat[own]++;
        end else if (ds_phase == 2) begin
            if (m_bvld_d && r_brdy[own]) begin
                ds_phase     = 0;
                rr_m         = (own == 0);
                r_phase[own] = 0;
                r_left[own]--;
                if (r_left[own] > 0) r_cur[own] = new_txn(own);
            end else if (ds_bdelay > 0) begin
                ds_bdelay--;
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (exp_aw[r]) begin
                r_phase[r] = 1;
                r_beat[r]  = 0;
                r_awvld[r] = 1'b0;
                gq.push_back(r_cur[r]);
            end
        end
        tog = ~tog;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        sample();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (!(r_left[0] == 0 && r_left[1] == 0 && ds_phase == 0 && gq.size() == 0)
               && n < budget) begin
            cycle();
            n++;
        end
        check_eq("done_in_budget", n < budget, 1'b1);
    endtask

    task automatic check_reset_values(input string p);
        check_eq({p, "_awrdy0"}, req0_if.awrdy, 1'b0);
        check_eq({p, "_awrdy1"}, req1_if.awrdy, 1'b0);
        check_eq({p, "_wrdy0"}, req0_if.wrdy, 1'b0);
        check_eq({p, "_wrdy1"}, req1_if.wrdy, 1'b0);
        check_eq({p, "_bvld0"}, req0_if.bvld, 1'b0);
        check_eq({p, "_bvld1"}, req1_if.bvld, 1'b0);
        check_eq({p, "_m_awvld"}, m_if.awvld, 1'b0);
        check_eq({p, "_m_aw_fields"}, m_cmd_bits(), 38'd0);
        check_eq({p, "_m_wvld"}, m_if.wvld, 1'b0);
        check_eq({p, "_m_wlast"}, m_if.wlast, 1'b0);
        check_eq({p, "_m_brdy"}, m_if.brdy, 1'b0);
        check_eq({p, "_err_beat"}, err_beat, 1'b0);
    endtask

    task automatic all_ready();
        p_req = 100; p_wvld = 100; p_brdy = 100; p_awrdy = 100; p_wrdy = 100;
    endtask

    initial begin
        int n;
        all_ready();
        len_max = 7; fixed_len = -1; aw_delay = 0; wrdy_toggle = 1'b0; bad_next = 1'b0;
        rst_n = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;

        // Single requester, 4-beat burst with fixed address and tag
        fixed_len = 3;
        load(1, 0);
        r_cur[0].addr  = 10'h040;
        r_cur[0].oram  = 12'h123;
        r_cur[0].bresp = 2'd0;
        run(100);

        // Both requesters saturated with single-beat bursts: strict alternation
        fixed_len = 0;
        load(4, 4);
        run(200);

        // Downstream command ready held low for 5 cycles
        aw_delay = 5; fixed_len = 1;
        load(1, 1);
        run(200);
        aw_delay = 0;

        // 256-beat burst with toggling write ready
        fixed_len = 255; wrdy_toggle = 1'b1;
        load(1, 0);
        run(1200);
        wrdy_toggle = 1'b0;

        // Randomized traffic
        fixed_len = -1;
        for (int i = 0; i < 6; i++) begin
            p_req   = int'($urandom_range(100, 20));
            p_wvld  = int'($urandom_range(100, 30));
            p_brdy  = int'($urandom_range(100, 30));
            p_awrdy = int'($urandom_range(100, 30));
            p_wrdy  = int'($urandom_range(100, 30));
            load(int'($urandom_range(8)), int'($urandom_range(8, 1)));
            run(3000);
        end
        all_ready();

        // Requester raises wlast on the first of two beats
        fixed_len = 1; bad_next = 1'b1;
        load(0, 1);
        run(100);
        bad_next = 1'b0;
        repeat (3) cycle();

        // Reset during beat 2 of a 4-beat burst, then a fresh request from req1
        fixed_len = 3;
        load(1, 0);
        n = 0;
        while (!(ds_phase == 1 && ds_beat == 1) && n < 50) begin
            cycle();
            n++;
        end
        check_eq("mid_rst_reached", ds_beat, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_reset_values("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load(0, 1);
        run(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
